// File: rtl/regfile_pkg.sv
// Shared encodings for the register-file sequencer: command opcodes, FSM states
// and default datapath widths.
package regfile_pkg;

  localparam int unsigned RF_DATA_W = 16;
  localparam int unsigned RF_ADDR_W = 4;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_MOV = 3'b101;
  localparam logic [2:0] OP_LDI = 3'b110;
  localparam logic [2:0] OP_CLR = 3'b111;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_RD   = 3'd1;
  localparam logic [2:0] S_RDW  = 3'd2;
  localparam logic [2:0] S_WB   = 3'd3;
  localparam logic [2:0] S_ZERO = 3'd4;

  // Ops that need both register operands fetched before write-back.
  function automatic logic needs_read(input logic [2:0] op);
    return (op <= OP_MOV);
  endfunction

endpackage

// File: rtl/regfile_sequencer_if.sv
// Command handshake and completion status between instruction decode (master)
// and the register-file sequencer (slave).
interface regfile_sequencer_if #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 4
);

  logic              req_valid;
  logic              req_ready;
  logic [2:0]        req_op;
  logic [ADDR_W-1:0] req_rd;
  logic [ADDR_W-1:0] req_rs1;
  logic [ADDR_W-1:0] req_rs2;
  logic [DATA_W-1:0] req_imm;

  logic              done;
  logic [DATA_W-1:0] result;
  logic              flag_z;
  logic              flag_c;

  modport master (
    output req_valid, req_op, req_rd, req_rs1, req_rs2, req_imm,
    input  req_ready, done, result, flag_z, flag_c
  );

  modport slave (
    input  req_valid, req_op, req_rd, req_rs1, req_rs2, req_imm,
    output req_ready, done, result, flag_z, flag_c
  );

endinterface

// File: rtl/regfile_sequencer_alu.sv
// Combinational ALU used in the read-wait stage: op -> {carry, result}.
// For SUB the carry is the no-borrow flag (1 when a >= b).
module seq_alu
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_W = RF_DATA_W
) (
  input  logic [2:0]        op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] y,
  output logic              c
);

  logic [DATA_W:0] wide;

  always_comb begin
    wide = '0;
    y    = '0;
    c    = 1'b0;
    case (op)
      OP_ADD: begin
        wide = {1'b0, a} + {1'b0, b};
        y    = wide[DATA_W-1:0];
        c    = wide[DATA_W];
      end
      OP_SUB: begin
        wide = {1'b0, a} - {1'b0, b};
        y    = wide[DATA_W-1:0];
        c    = ~wide[DATA_W];
      end
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      OP_XOR:  y = a ^ b;
      OP_MOV:  y = a;
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/regfile_sequencer.sv
// Initiator-side controller for the register file: fetches operands, runs one
// ALU op, writes back, and can sweep every register to zero.
module regfile_sequencer
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_W = RF_DATA_W,
  parameter int unsigned ADDR_W = RF_ADDR_W,
  parameter int unsigned NREGS  = 2 ** ADDR_W
) (
  input  logic              clock,
  input  logic              clear,
  regfile_sequencer_if.slave req,
  output logic [ADDR_W-1:0] read_reg1,
  output logic [ADDR_W-1:0] read_reg2,
  input  logic [DATA_W-1:0] read_data1,
  input  logic [DATA_W-1:0] read_data2,
  output logic [ADDR_W-1:0] write_reg,
  output logic [DATA_W-1:0] write_data,
  output logic              regWrite
);

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NREGS - 1);

  logic [2:0]        state;
  logic              ready_q;
  logic [2:0]        op_q;
  logic [ADDR_W-1:0] rd_q;
  logic [ADDR_W-1:0] cnt;
  logic [ADDR_W-1:0] cnt_nxt;
  logic              done_q;
  logic [DATA_W-1:0] result_q;
  logic              flag_z_q;
  logic              flag_c_q;
  logic [DATA_W-1:0] alu_y;
  logic              alu_c;

  assign cnt_nxt = cnt + ADDR_W'(1);

  seq_alu #(.DATA_W(DATA_W)) u_alu (
    .op (op_q),
    .a  (read_data1),
    .b  (read_data2),
    .y  (alu_y),
    .c  (alu_c)
  );

  // Every output is a flop; regWrite/done default low so they only pulse in
  // the cycles explicitly scheduled below.
  always_ff @(posedge clock) begin
    if (!clear) begin
      state      <= S_IDLE;
      ready_q    <= 1'b1;
      op_q       <= OP_ADD;
      rd_q       <= '0;
      cnt        <= '0;
      read_reg1  <= '0;
      read_reg2  <= '0;
      write_reg  <= '0;
      write_data <= '0;
      regWrite   <= 1'b0;
      done_q     <= 1'b0;
      result_q   <= '0;
      flag_z_q   <= 1'b0;
      flag_c_q   <= 1'b0;
    end else begin
      regWrite <= 1'b0;
      done_q   <= 1'b0;
      case (state)
        S_IDLE: begin
          if (req.req_valid && ready_q) begin
            op_q    <= req.req_op;
            rd_q    <= req.req_rd;
            ready_q <= 1'b0;
            if (needs_read(req.req_op)) begin
              state     <= S_RD;
              read_reg1 <= req.req_rs1;
              read_reg2 <= req.req_rs2;
            end else if (req.req_op == OP_LDI) begin
              // LDI skips the read stages and is in write-back immediately.
              state      <= S_WB;
              regWrite   <= 1'b1;
              write_reg  <= req.req_rd;
              write_data <= req.req_imm;
              done_q     <= 1'b1;
              result_q   <= req.req_imm;
              flag_z_q   <= (req.req_imm == '0);
              flag_c_q   <= 1'b0;
            end else begin
              state      <= S_ZERO;
              cnt        <= '0;
              regWrite   <= 1'b1;
              write_reg  <= '0;
              write_data <= '0;
            end
          end
        end
        S_RD: state <= S_RDW;
        S_RDW: begin
          state      <= S_WB;
          regWrite   <= 1'b1;
          write_reg  <= rd_q;
          write_data <= alu_y;
          done_q     <= 1'b1;
          result_q   <= alu_y;
          flag_z_q   <= (alu_y == '0);
          flag_c_q   <= alu_c;
        end
        S_WB: begin
          state   <= S_IDLE;
          ready_q <= 1'b1;
        end
        S_ZERO: begin
          if (cnt == LAST) begin
            state   <= S_IDLE;
            ready_q <= 1'b1;
          end else begin
            cnt        <= cnt_nxt;
            regWrite   <= 1'b1;
            write_reg  <= cnt_nxt;
            write_data <= '0;
            if (cnt_nxt == LAST) begin
              done_q   <= 1'b1;
              result_q <= '0;
              flag_z_q <= 1'b1;
              flag_c_q <= 1'b0;
            end
          end
        end
        default: begin
          state   <= S_IDLE;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign req.req_ready = ready_q;
  assign req.done      = done_q;
  assign req.result    = result_q;
  assign req.flag_z    = flag_z_q;
  assign req.flag_c    = flag_c_q;

endmodule

// File: tb/tb_regfile_sequencer.sv
// Sequencer paired with a behavioural 16x16 register file, checked against an
// arithmetic reference model of the command set.
module tb_regfile_sequencer;

  localparam int DW = 16;
  localparam int AW = 4;

  logic clock = 1'b0;
  logic clear = 1'b0;
  always #5 clock = ~clock;

  regfile_sequencer_if #(.DATA_W(DW), .ADDR_W(AW)) req_if ();

  logic [AW-1:0] read_reg1, read_reg2, write_reg;
  logic [DW-1:0] read_data1, read_data2, write_data;
  logic          regWrite;

  regfile_sequencer #(.DATA_W(DW), .ADDR_W(AW), .NREGS(16)) dut (
    .clock      (clock),
    .clear      (clear),
    .req        (req_if),
    .read_reg1  (read_reg1),
    .read_reg2  (read_reg2),
    .read_data1 (read_data1),
    .read_data2 (read_data2),
    .write_reg  (write_reg),
    .write_data (write_data),
    .regWrite   (regWrite)
  );

  // Register file: synchronous read, write commits at the edge ending the write cycle.
  logic [DW-1:0] rf [16];
  always @(posedge clock) begin
    if (regWrite) rf[write_reg] <= write_data;
    read_data1 <= rf[read_reg1];
    read_data2 <= rf[read_reg2];
  end

  int unsigned mdl [16];
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  function automatic void ref_op(input int op, input int unsigned a, input int unsigned b,
                                 input int unsigned imm, output int unsigned y, output int unsigned c);
    c = 0;
    case (op)
      0: begin y = (a + b) % 65536; c = (a + b) / 65536; end
      1: begin y = (a + 65536 - b) % 65536; c = (a >= b) ? 1 : 0; end
      2: y = a & b;
      3: y = a | b;
      4: y = a ^ b;
      5: y = a;
      6: y = imm;
      default: y = 0;
    endcase
  endfunction

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rr1"},   read_reg1, 0);
    check({tag, "_rr2"},   read_reg2, 0);
    check({tag, "_wreg"},  write_reg, 0);
    check({tag, "_wdata"}, write_data, 0);
    check({tag, "_we"},    regWrite, 0);
    check({tag, "_done"},  req_if.done, 0);
    check({tag, "_res"},   req_if.result, 0);
    check({tag, "_z"},     req_if.flag_z, 0);
    check({tag, "_c"},     req_if.flag_c, 0);
    check({tag, "_ready"}, req_if.req_ready, 1);
  endtask

  task automatic compare_file(input string tag);
    for (int i = 0; i < 16; i++) check(tag, rf[i], mdl[i]);
  endtask

  // Issue one command from an idle cycle and follow it to completion.
  task automatic do_cmd(input int op, input int rd, input int rs1, input int rs2, input int unsigned imm);
    int unsigned y, c;
    int exp_k, wr_cnt;
    bit fin;
    ref_op(op, mdl[rs1], mdl[rs2], imm, y, c);
    exp_k = (op == 6) ? 0 : (op == 7) ? 15 : 2;
    check("ready_idle", req_if.req_ready, 1);
    req_if.req_valid = 1'b1;
    req_if.req_op    = 3'(op);
    req_if.req_rd    = AW'(rd);
    req_if.req_rs1   = AW'(rs1);
    req_if.req_rs2   = AW'(rs2);
    req_if.req_imm   = DW'(imm);
    @(posedge clock); #1;
    req_if.req_valid = 1'b0;
    wr_cnt = 0;
    fin    = 1'b0;
    for (int k = 0; k < 40 && !fin; k++) begin
      if (k == 0 && op < 6) begin
        check("rd_addr1", read_reg1, rs1);
        check("rd_addr2", read_reg2, rs2);
      end
      check("busy_ready", req_if.req_ready, 0);
      if (regWrite) begin
        if (op == 7) begin
          check("clr_reg", write_reg, wr_cnt);
          check("clr_data", write_data, 0);
        end else begin
          check("wr_cycle", k, exp_k);
          check("wr_reg", write_reg, rd);
          check("wr_data", write_data, y);
        end
        wr_cnt++;
      end
      if (req_if.done) begin
        check("done_cycle", k, exp_k);
        check("result", req_if.result, y);
        check("flag_z", req_if.flag_z, (y == 0) ? 1 : 0);
        check("flag_c", req_if.flag_c, c);
        fin = 1'b1;
      end
      @(posedge clock); #1;
    end
    if (!fin) check("done_timeout", 0, 1);
    check("write_count", wr_cnt, (op == 7) ? 16 : 1);
    if (op == 7) for (int i = 0; i < 16; i++) mdl[i] = 0;
    else mdl[rd] = y;
  endtask

  initial begin
    int wr_k [$];
    int wr_r [$];
    int wr_d [$];
    int ready_k;
    int done_n;

    req_if.req_valid = 1'b0;
    req_if.req_op    = '0;
    req_if.req_rd    = '0;
    req_if.req_rs1   = '0;
    req_if.req_rs2   = '0;
    req_if.req_imm   = '0;

    repeat (3) @(posedge clock);
    #1;
    check_reset_outputs("reset");
    clear = 1'b1;

    do_cmd(6, 1, 0, 0, 16'h0001);
    @(posedge clock); #1;
    check("ldi_r1", rf[1], 16'h0001);

    for (int i = 0; i < 16; i++)
      if (i != 1) do_cmd(6, i, 0, 0, $urandom_range(0, 65535));
    do_cmd(6, 2, 0, 0, 16'hFFFF);
    do_cmd(6, 3, 0, 0, 16'h0001);
    do_cmd(0, 4, 2, 3, 0);
    check("add_z", req_if.flag_z, 1);
    check("add_c", req_if.flag_c, 1);
    check("add_r4", rf[4], 16'h0000);
    do_cmd(1, 5, 3, 2, 0);
    check("sub_c", req_if.flag_c, 0);
    check("sub_r5", rf[5], 16'h0002);
    do_cmd(4, 6, 2, 2, 0);
    check("xor_r6", rf[6], 16'h0000);

    // ADD r7=r1+r1, then MOV r8=r7 presented while the ADD is still busy.
    req_if.req_valid = 1'b1;
    req_if.req_op    = 3'b000;
    req_if.req_rd    = 4'd7;
    req_if.req_rs1   = 4'd1;
    req_if.req_rs2   = 4'd1;
    @(posedge clock); #1;
    req_if.req_op  = 3'b101;
    req_if.req_rd  = 4'd8;
    req_if.req_rs1 = 4'd7;
    req_if.req_rs2 = 4'd0;
    ready_k = -1;
    done_n  = 0;
    for (int k = 0; k < 8; k++) begin
      if (regWrite) begin
        wr_k.push_back(k);
        wr_r.push_back(int'(write_reg));
        wr_d.push_back(int'(write_data));
      end
      if (req_if.done) done_n++;
      if (req_if.req_ready && ready_k < 0) ready_k = k;
      if (k == 4) begin
        req_if.req_valid = 1'b0;
        check("b2b_rr1", read_reg1, 7);
      end
      @(posedge clock); #1;
    end
    mdl[7] = (mdl[1] * 2) % 65536;
    mdl[8] = mdl[7];
    check("b2b_ready_k", ready_k, 3);
    check("b2b_done_n", done_n, 2);
    check("b2b_wr_n", wr_k.size(), 2);
    if (wr_k.size() == 2) begin
      check("b2b_k0", wr_k[0], 2);
      check("b2b_r0", wr_r[0], 7);
      check("b2b_d0", wr_d[0], 2);
      check("b2b_k1", wr_k[1], 6);
      check("b2b_r1", wr_r[1], 8);
      check("b2b_d1", wr_d[1], 2);
    end
    check("b2b_r8", rf[8], 16'h0002);

    for (int n = 0; n < 40; n++)
      do_cmd($urandom_range(0, 6), $urandom_range(0, 15), $urandom_range(0, 15),
             $urandom_range(0, 15), $urandom_range(0, 65535));
    compare_file("rand_file");

    do_cmd(7, 0, 0, 0, 0);
    compare_file("clr_file");

    for (int i = 0; i < 16; i++) do_cmd(6, i, 0, 0, $urandom_range(1, 65535));

    // Abort a CLR sweep during its fifth write cycle.
    req_if.req_valid = 1'b1;
    req_if.req_op    = 3'b111;
    @(posedge clock); #1;
    req_if.req_valid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      check("abort_we", regWrite, 1);
      check("abort_reg", write_reg, k);
      if (k < 4) begin
        @(posedge clock); #1;
      end
    end
    clear = 1'b0;
    @(posedge clock); #1;
    check_reset_outputs("abort");
    clear = 1'b1;
    for (int i = 0; i < 5; i++) mdl[i] = 0;
    repeat (3) begin
      @(posedge clock); #1;
      check("post_abort_we", regWrite, 0);
    end
    compare_file("abort_file");

    for (int n = 0; n < 10; n++)
      do_cmd($urandom_range(0, 6), $urandom_range(0, 15), $urandom_range(0, 15),
             $urandom_range(0, 15), $urandom_range(0, 65535));
    compare_file("final_file");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
